// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter, core priority with debug starvation guard
module dmem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              d_starved
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0]        wait_cnt;
    logic              override;
    logic [RD_LAT-1:0] tag_v;
    logic [RD_LAT-1:0] tag_id;
    logic [DATA_W-1:0] c_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    // Grants are gated by reset so they drop the instant reset rises.
    always_comb begin
        override  = ~reset & d_req & (wait_cnt == LIMIT);
        c_gnt     = ~reset & c_req & ~override;
        d_gnt     = ~reset & (override | (d_req & ~c_req));
        d_starved = override;
        mem_en    = c_gnt | d_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (c_gnt) begin
            mem_we    = c_we;
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
        end else if (d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (d_gnt || !d_req) begin
            wait_cnt <= '0;
        end else if (wait_cnt != LIMIT) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Owner tag travels alongside the memory read so data lands at the right port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v[0]  <= mem_en & ~mem_we;
            tag_id[0] <= d_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    assign c_rvalid = tag_v[RD_LAT-1] & ~tag_id[RD_LAT-1];
    assign d_rvalid = tag_v[RD_LAT-1] & tag_id[RD_LAT-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (c_rvalid) c_rdata_q <= mem_rdata;
            if (d_rvalid) d_rdata_q <= mem_rdata;
        end
    end

    assign c_rdata = c_rvalid ? mem_rdata : c_rdata_q;
    assign d_rdata = d_rvalid ? mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int AW     = 16;
    localparam int DW     = 16;
    localparam int RD_LAT = 2;
    localparam int LIMIT  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          c_req, c_we, d_req, d_we;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wdata, d_wdata;
    logic          c_gnt, c_rvalid, d_gnt, d_rvalid;
    logic [DW-1:0] c_rdata, d_rdata;
    logic          mem_en, mem_we, d_starved;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .d_starved(d_starved)
    );

    // Memory model: 256 words (address aliased on low byte), RD_LAT read pipeline.
    logic [DW-1:0] mem_array [0:255];
    logic [255:0]  written = '0;
    logic [DW-1:0] rd_pipe [0:RD_LAT-1];

    function automatic logic [DW-1:0] pattern(input logic [7:0] a);
        return {a, ~a} ^ 16'h3C00;
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem_array[mem_addr[7:0]] <= mem_wdata;
            written[mem_addr[7:0]]   <= 1'b1;
        end
        rd_pipe[0] <= written[mem_addr[7:0]] ? mem_array[mem_addr[7:0]] : pattern(mem_addr[7:0]);
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    // Reference shadow of memory contents
    logic [DW-1:0] ref_mem [0:255];
    bit            ref_wr  [0:255];

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_wr[a[7:0]] ? ref_mem[a[7:0]] : pattern(a[7:0]);
    endfunction

    task automatic ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ref_mem[a[7:0]] = d;
        ref_wr[a[7:0]]  = 1'b1;
    endtask

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic set_c(input logic r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        c_req = r; c_we = we; c_addr = a; c_wdata = d;
    endtask

    task automatic set_d(input logic r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        d_req = r; d_we = we; d_addr = a; d_wdata = d;
    endtask

    task automatic idle();
        set_c(0, 0, '0, '0);
        set_d(0, 0, '0, '0);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        idle();
        for (int i = 0; i < n; i++) next();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_flags"}, {c_gnt, d_gnt, mem_en, mem_we, d_starved, c_rvalid, d_rvalid}, 0);
        chk({name, "_maddr"}, mem_addr, 0);
        chk({name, "_mwdata"}, mem_wdata, 0);
        chk({name, "_crdata"}, c_rdata, 0);
        chk({name, "_drdata"}, d_rdata, 0);
    endtask

    typedef struct {
        logic          cr, cw;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        logic          dr, dw;
        logic [AW-1:0] da;
        logic [DW-1:0] dd;
        logic          ecg, edg, ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
    } vec_t;

    typedef struct {
        int            due;
        bit            own;
        logic [DW-1:0] data;
    } rsp_t;

    initial begin
        vec_t vecs[7];
        rsp_t q[$];
        rsp_t r;
        bit cp, dp, ov, eg_c, eg_d, ecv, edv;
        int m_wait;
        logic [DW-1:0] last_c, last_d;

        vecs[0] = '{0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0,0,16'h0000,16'h0000};
        vecs[1] = '{1,1,16'h0001,16'hBEEF, 0,0,16'h0000,16'h0000, 1,0,1,16'h0001,16'hBEEF};
        vecs[2] = '{1,0,16'h0001,16'hAAAA, 1,1,16'h0050,16'h1234, 1,0,0,16'h0001,16'hAAAA};
        vecs[3] = '{0,0,16'h0000,16'h0000, 1,0,16'h0010,16'h0000, 0,1,0,16'h0010,16'h0000};
        vecs[4] = '{0,0,16'h0000,16'h0000, 1,1,16'hFFFF,16'h00FF, 0,1,1,16'hFFFF,16'h00FF};
        vecs[5] = '{1,1,16'h0002,16'h1111, 1,1,16'h0003,16'h2222, 1,0,1,16'h0002,16'h1111};
        vecs[6] = '{1,0,16'h0004,16'h0000, 0,0,16'h0000,16'h0000, 1,0,0,16'h0004,16'h0000};

        // Reset: requests asserted must still see everything low
        reset = 1'b1;
        set_c(1, 1, 16'h1234, 16'h5678);
        set_d(1, 1, 16'h4321, 16'h8765);
        sample();
        chk_all_zero("reset");
        next();
        next();
        reset = 1'b0;
        idle();
        next();

        // Single-cycle grant / mux vectors
        foreach (vecs[i]) begin
            set_c(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd);
            set_d(vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].dd);
            sample();
            chk($sformatf("vec%0d_cgnt", i), c_gnt, vecs[i].ecg);
            chk($sformatf("vec%0d_dgnt", i), d_gnt, vecs[i].edg);
            chk($sformatf("vec%0d_men", i), mem_en, vecs[i].ecg | vecs[i].edg);
            chk($sformatf("vec%0d_mwe", i), mem_we, vecs[i].ewe);
            chk($sformatf("vec%0d_maddr", i), mem_addr, vecs[i].ea);
            chk($sformatf("vec%0d_mwdata", i), mem_wdata, vecs[i].ed);
            chk($sformatf("vec%0d_starved", i), d_starved, 0);
            if (vecs[i].ecg && vecs[i].cw) ref_write(vecs[i].ca, vecs[i].cd);
            if (vecs[i].edg && vecs[i].dw) ref_write(vecs[i].da, vecs[i].dd);
            next();
        end
        idle_cycles(RD_LAT + 1);

        // Core only: write then read back
        set_c(1, 1, 16'h0001, 16'hBEEF);
        sample();
        chk("core_wr_gnt", c_gnt, 1);
        ref_write(16'h0001, 16'hBEEF);
        next();
        set_c(1, 0, 16'h0001, 16'h0000);
        sample();
        chk("core_rd_gnt", c_gnt, 1);
        next();
        idle();
        for (int k = 1; k <= RD_LAT + 1; k++) begin
            sample();
            chk($sformatf("core_rvalid_k%0d", k), c_rvalid, k == RD_LAT);
            chk($sformatf("core_drvalid_k%0d", k), d_rvalid, 0);
            if (k >= RD_LAT) chk($sformatf("core_rdata_k%0d", k), c_rdata, 16'hBEEF);
            next();
        end

        // Contention: debug wins every (LIMIT+1)th cycle
        for (int n = 1; n <= 3 * (LIMIT + 1); n++) begin
            set_c(1, 0, 16'h0020, 16'h0000);
            set_d(1, 0, 16'h0010, 16'h0000);
            sample();
            chk($sformatf("cont%0d_dgnt", n), d_gnt, (n % (LIMIT + 1)) == 0);
            chk($sformatf("cont%0d_starved", n), d_starved, (n % (LIMIT + 1)) == 0);
            chk($sformatf("cont%0d_cgnt", n), c_gnt, (n % (LIMIT + 1)) != 0);
            next();
        end
        idle_cycles(RD_LAT + 1);

        // Idle core: debug reads 0..3 back-to-back
        for (int j = 0; j < 4 + RD_LAT; j++) begin
            if (j < 4) set_d(1, 0, AW'(j), 16'h0000);
            else idle();
            sample();
            chk($sformatf("dbg%0d_gnt", j), d_gnt, j < 4);
            chk($sformatf("dbg%0d_wait", j), dut.wait_cnt, 0);
            chk($sformatf("dbg%0d_crvalid", j), c_rvalid, 0);
            if (j >= RD_LAT && j - RD_LAT < 4) begin
                chk($sformatf("dbg%0d_rvalid", j), d_rvalid, 1);
                chk($sformatf("dbg%0d_rdata", j), d_rdata, ref_rd(AW'(j - RD_LAT)));
            end else begin
                chk($sformatf("dbg%0d_rvalid", j), d_rvalid, 0);
            end
            next();
        end

        // Interleaved reads from alternating owners
        set_c(1, 1, 16'h0003, 16'h2222);
        ref_write(16'h0003, 16'h2222);
        next();
        for (int j = 0; j <= RD_LAT + 2; j++) begin
            idle();
            if (j == 0) set_c(1, 0, 16'h0002, 16'h0000);
            if (j == 1) set_d(1, 0, 16'h0003, 16'h0000);
            sample();
            if (j == 0) chk("il_cgnt", c_gnt, 1);
            if (j == 1) chk("il_dgnt", d_gnt, 1);
            chk($sformatf("il%0d_crvalid", j), c_rvalid, j == RD_LAT);
            chk($sformatf("il%0d_drvalid", j), d_rvalid, j == RD_LAT + 1);
            if (j == RD_LAT) chk("il_crdata", c_rdata, 16'h1111);
            if (j == RD_LAT + 1) begin
                chk("il_drdata", d_rdata, 16'h2222);
                chk("il_crdata_hold", c_rdata, 16'h1111);
            end
            next();
        end

        // Debug write only
        idle();
        set_d(1, 1, 16'hFFFF, 16'h00FF);
        sample();
        chk("wr_dgnt", d_gnt, 1);
        chk("wr_men", mem_en, 1);
        chk("wr_mwe", mem_we, 1);
        chk("wr_maddr", mem_addr, 16'hFFFF);
        chk("wr_mwdata", mem_wdata, 16'h00FF);
        ref_write(16'hFFFF, 16'h00FF);
        next();
        idle();
        for (int k = 1; k <= RD_LAT + 1; k++) begin
            sample();
            chk($sformatf("wr_norv_k%0d", k), {c_rvalid, d_rvalid}, 0);
            next();
        end

        // Reset one cycle after a granted read
        set_c(1, 0, 16'h0005, 16'h0000);
        set_d(1, 0, 16'h0006, 16'h0000);
        sample();
        chk("mr_cgnt", c_gnt, 1);
        next();
        reset = 1'b1;
        sample();
        chk_all_zero("midrst");
        chk("midrst_wait", dut.wait_cnt, 0);
        next();
        reset = 1'b0;
        idle();
        for (int k = 1; k <= RD_LAT + 1; k++) begin
            sample();
            chk($sformatf("mr_norv_k%0d", k), {c_rvalid, d_rvalid}, 0);
            chk($sformatf("mr_wait_k%0d", k), dut.wait_cnt, 0);
            next();
        end
        set_c(1, 0, 16'h0005, 16'h0000);
        set_d(1, 0, 16'h0006, 16'h0000);
        sample();
        chk("mr_first_cgnt", c_gnt, 1);
        chk("mr_first_dgnt", d_gnt, 0);
        next();

        // Clean restart, then randomized traffic against the reference model
        reset = 1'b1;
        idle();
        next();
        reset = 1'b0;
        next();
        cp = 0; dp = 0; m_wait = 0; last_c = '0; last_d = '0;
        for (int n = 0; n < 400; n++) begin
            if (!cp) begin
                cp = $urandom_range(0, 3) != 0;
                set_c(cp, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
            end
            if (!dp) begin
                dp = $urandom_range(0, 2) == 0;
                set_d(dp, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
            end
            sample();
            ov   = dp && (m_wait == LIMIT);
            eg_d = ov || (dp && !cp);
            eg_c = cp && !ov;
            chk("rnd_cgnt", c_gnt, eg_c);
            chk("rnd_dgnt", d_gnt, eg_d);
            chk("rnd_starved", d_starved, ov);
            if (eg_c) chk("rnd_maddr_c", mem_addr, c_addr);
            if (eg_d) chk("rnd_maddr_d", mem_addr, d_addr);
            ecv = 0; edv = 0;
            if (q.size() > 0 && q[0].due == n) begin
                r = q.pop_front();
                if (r.own) begin edv = 1; last_d = r.data; end
                else       begin ecv = 1; last_c = r.data; end
            end
            chk("rnd_crvalid", c_rvalid, ecv);
            chk("rnd_drvalid", d_rvalid, edv);
            chk("rnd_crdata", c_rdata, last_c);
            chk("rnd_drdata", d_rdata, last_d);
            if (eg_c) begin
                if (c_we) ref_write(c_addr, c_wdata);
                else q.push_back('{n + RD_LAT, 1'b0, ref_rd(c_addr)});
                cp = 0;
            end
            if (eg_d) begin
                if (d_we) ref_write(d_addr, d_wdata);
                else q.push_back('{n + RD_LAT, 1'b1, ref_rd(d_addr)});
                dp = 0;
            end
            m_wait = (eg_d || !dp) ? 0 : ((m_wait < LIMIT) ? m_wait + 1 : LIMIT);
            next();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 16-bit data memory between two requesters: port 0 is the CPU core load/store path and port 1 is the debug/dump engine, which reads out memory words and writes back patches after halt or while running.
- The core has priority. A starvation guard forces a grant to the debug port after it has waited STARVE_LIMIT cycles.
- Read data is tagged by owner and routed back with fixed latency.
- Sits between the core and the data memory inside the top level.

Parameters:
- ADDR_W, 16: address width.
- DATA_W, 16: data width.
- RD_LAT, 1: memory read latency in cycles (legal range 1..4).
- STARVE_LIMIT, 8: number of consecutive blocked cycles after which the debug port wins (legal range 1..255).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- c_req  in  1  core access request.
- c_we  in  1  core write enable (0 = read).
- c_addr  in  ADDR_W  core address.
- c_wdata  in  DATA_W  core write data.
- c_gnt  out  1  core access accepted this cycle.
- c_rvalid  out  1  core read data valid.
- c_rdata  out  DATA_W  core read data.
- d_req, d_we, d_addr, d_wdata  in  1/1/ADDR_W/DATA_W  debug port request fields, same meaning as the core fields.
- d_gnt, d_rvalid, d_rdata  out  1/1/DATA_W  debug port responses, same meaning as the core responses.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after mem_en with mem_we=0.
- d_starved  out  1  high in any cycle where the starvation override grants the debug port.

Behaviour:
- Reset: all outputs are 0; the wait counter and the response tag pipeline are cleared. Any read in flight at reset is dropped, with no rvalid afterwards.
- Handshake: a requester holds req and its fields stable until gnt is seen. A transfer occurs in a cycle where req and gnt are both high. gnt is combinational from req and the registered state.
- Grant rule, evaluated each cycle:
  - override = d_req and (wait_cnt == STARVE_LIMIT).
  - If override: d_gnt = 1.
  - Else if c_req: c_gnt = 1.
  - Else if d_req: d_gnt = 1.
  - At most one gnt is high per cycle.
- Memory mux: mem_en = c_gnt | d_gnt. mem_we, mem_addr and mem_wdata come from the granted port. With no grant they are 0.
- wait_cnt (8-bit):
  - Cleared when d_gnt is high or d_req is low.
  - Otherwise increments and saturates at STARVE_LIMIT.
  - After an override the core wins again on the next cycle, and the debug port must wait another STARVE_LIMIT cycles.
- d_starved = override.
- Read response:
  - A granted read pushes an owner tag (valid, id) into an RD_LAT-deep shift register. Writes push valid = 0.
  - At the pipe output, the owner's rvalid pulses for 1 cycle and its rdata = mem_rdata.
  - The non-owner's rdata is held at its last value and its rvalid is 0.
  - Back-to-back reads from alternating owners are supported at 1 access per cycle. The responses arrive in issue order.
- Write followed by read to the same address in consecutive cycles returns the new data. This is a memory property and is passed through unchanged.
- Reset asserted mid-operation: gnt and mem_en drop combinationally and immediately. Tags are cleared.

Test Plan:
- Core only:
  - Stimulus: core writes 0xBEEF to 0x0001, then reads 0x0001.
  - Required response: c_gnt in both cycles. c_rvalid=1 with c_rdata=0xBEEF exactly RD_LAT cycles after the read grant. d_rvalid stays 0.
- Contention:
  - Stimulus: c_req and d_req held high continuously, debug port reading 0x0010, STARVE_LIMIT=8.
  - Required response: d_gnt and d_starved high on cycle 9, then on every 9th cycle. c_gnt on all other cycles.
- Idle core:
  - Stimulus: d_req only, reading addresses 0..3 back-to-back.
  - Required response: d_gnt on 4 consecutive cycles. d_rvalid on 4 consecutive cycles returning mem[0..3] in order. wait_cnt stays 0.
- Interleaved reads:
  - Stimulus: core read of 0x0002 (value 0x1111), then debug read of 0x0003 (value 0x2222) on the next cycle.
  - Required response: c_rvalid carries 0x1111, then d_rvalid carries 0x2222 one cycle later. No cross-routing.
- Reset mid-read:
  - Stimulus: reset asserted one cycle after a granted read with RD_LAT=2.
  - Required response: no rvalid, all outputs 0, wait_cnt 0. After release, the first grant follows the normal rule.
- Writes only:
  - Stimulus: debug write of 0x00FF to 0xFFFF while the core is idle.
  - Required response: mem_en=1, mem_we=1, mem_addr=0xFFFF, mem_wdata=0x00FF in the same cycle. No rvalid follows.
